// File: rtl/vend_pkg.sv
// vend_pkg: shared constants, types and helper functions for the vending
// machine transaction sequencer.
//   - slot count, credit limit and arithmetic width
//   - coin codes with their cent values
//   - top-level state enum and display mode codes
package vend_pkg;

  localparam int NUM_SLOTS  = 9;
  localparam int MAX_CREDIT = 500;
  localparam int VAL_W      = 10;
  localparam int SLOT_W     = 4;

  localparam logic [SLOT_W-1:0] LAST_SLOT = 4'd8;

  localparam logic [2:0] COIN_5   = 3'd0;
  localparam logic [2:0] COIN_10  = 3'd1;
  localparam logic [2:0] COIN_25  = 3'd2;
  localparam logic [2:0] COIN_50  = 3'd3;
  localparam logic [2:0] COIN_100 = 3'd4;
  localparam logic [2:0] COIN_500 = 3'd5;

  localparam logic [1:0] MODE_CREDIT = 2'd0;
  localparam logic [1:0] MODE_PRICE  = 2'd1;
  localparam logic [1:0] MODE_CHANGE = 2'd2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CREDIT   = 3'd1,
    DISPENSE = 3'd2,
    PAYOUT   = 3'd3,
    RETURN   = 3'd4
  } state_e;

  // Cent value of a coin code; the two unused codes are worth nothing.
  function automatic logic [VAL_W-1:0] coin_value(input logic [2:0] code);
    logic [VAL_W-1:0] v;
    case (code)
      COIN_5:   v = 10'd5;
      COIN_10:  v = 10'd10;
      COIN_25:  v = 10'd25;
      COIN_50:  v = 10'd50;
      COIN_100: v = 10'd100;
      COIN_500: v = 10'd500;
      default:  v = 10'd0;
    endcase
    return v;
  endfunction

  function automatic logic coin_is_valid(input logic [2:0] code);
    return (code <= COIN_500);
  endfunction

  // Largest change coin not exceeding the amount. The machine only pays
  // change in 100/25/10/5; below 5 the caller stops before asking.
  function automatic logic [2:0] change_coin(input logic [VAL_W-1:0] amt);
    logic [2:0] c;
    if (amt >= 10'd100) begin
      c = COIN_100;
    end else if (amt >= 10'd25) begin
      c = COIN_25;
    end else if (amt >= 10'd10) begin
      c = COIN_10;
    end else begin
      c = COIN_5;
    end
    return c;
  endfunction

endpackage

// File: rtl/vend_payout.sv
// vend_payout: greedy change payer. A start pulse loads the amount; the block
// then ejects one coin at a time through the eject req/ack handshake and
// pulses done once less than 5c remains (the sub-5c remainder is dropped).
//   start_i/amount_i : load request and amount in cents
//   eject_ack_i      : ejector released the current coin
//   eject_req_o/eject_coin_o : coin request, stable until acknowledged
//   remaining_o      : change still owed, active_o : payout in progress
//   done_o           : one-cycle completion pulse
module vend_payout
  import vend_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [VAL_W-1:0] amount_i,
  input  logic             eject_ack_i,
  output logic             eject_req_o,
  output logic [2:0]       eject_coin_o,
  output logic [VAL_W-1:0] remaining_o,
  output logic             active_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_PICK = 2'd1,
    P_WAIT = 2'd2
  } pay_state_e;

  pay_state_e       state_q;
  logic [VAL_W-1:0] amt_q;
  logic             req_q;
  logic [2:0]       coin_q;
  logic             done_q;

  // Pick/wait loop; the pick cycle after every ack keeps the request low
  // for one cycle between consecutive coins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= P_IDLE;
      amt_q   <= 10'd0;
      req_q   <= 1'b0;
      coin_q  <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        P_IDLE: begin
          if (start_i) begin
            amt_q   <= amount_i;
            state_q <= P_PICK;
          end
        end
        P_PICK: begin
          if (amt_q < 10'd5) begin
            amt_q   <= 10'd0;
            done_q  <= 1'b1;
            state_q <= P_IDLE;
          end else begin
            coin_q  <= change_coin(amt_q);
            req_q   <= 1'b1;
            state_q <= P_WAIT;
          end
        end
        P_WAIT: begin
          if (eject_ack_i) begin
            req_q   <= 1'b0;
            amt_q   <= amt_q - coin_value(coin_q);
            state_q <= P_PICK;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= P_IDLE;
        end
      endcase
    end
  end

  assign eject_req_o  = req_q;
  assign eject_coin_o = coin_q;
  assign remaining_o  = amt_q;
  assign active_o     = (state_q != P_IDLE);
  assign done_o       = done_q;

endmodule

// File: rtl/vend_controller.sv
// vend_controller: vending machine transaction sequencer.
//   coin_valid/coin_code, sel_valid/sel_slot, cancel : one-cycle user strobes
//   cfg_we/cfg_slot/cfg_price/cfg_stock : price and stock table write (IDLE only)
//   dispense_req/dispense_slot/dispense_ack : dispenser handshake
//   eject_req/eject_coin/eject_ack : coin ejector handshake (change or rejected coin)
//   credit, disp_value, disp_mode : credit and display formatter feed
//   grn_led/red_led : per-slot affordable / unavailable indicators
//   busy : high while dispensing, paying out or returning a coin
module vend_controller
  import vend_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coin_valid,
  input  logic [2:0]           coin_code,
  input  logic                 sel_valid,
  input  logic [3:0]           sel_slot,
  input  logic                 cancel,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_slot,
  input  logic [8:0]           cfg_price,
  input  logic [3:0]           cfg_stock,
  output logic                 dispense_req,
  output logic [3:0]           dispense_slot,
  input  logic                 dispense_ack,
  output logic                 eject_req,
  output logic [2:0]           eject_coin,
  input  logic                 eject_ack,
  output logic [VAL_W-1:0]     credit,
  output logic [VAL_W-1:0]     disp_value,
  output logic [1:0]           disp_mode,
  output logic [NUM_SLOTS-1:0] grn_led,
  output logic [NUM_SLOTS-1:0] red_led,
  output logic                 busy
);

  state_e               state_q;
  logic [VAL_W-1:0]     credit_q;
  logic [VAL_W-1:0]     change_q;
  logic [8:0]           price_q [NUM_SLOTS];
  logic [3:0]           stock_q [NUM_SLOTS];
  logic                 disp_req_q;
  logic [3:0]           disp_slot_q;
  logic                 ret_req_q;
  logic [2:0]           ret_coin_q;
  logic [VAL_W-1:0]     disp_value_q;
  logic [1:0]           disp_mode_q;
  logic [NUM_SLOTS-1:0] grn_q;
  logic [NUM_SLOTS-1:0] red_q;
  logic                 busy_q;
  logic                 pay_start_q;

  logic [VAL_W-1:0]     sel_price_s;
  logic [3:0]           sel_stock_s;
  logic                 sel_ok_s;
  logic [VAL_W-1:0]     coin_val_s;
  logic [VAL_W:0]       sum_s;

  logic                 pay_req_s;
  logic [2:0]           pay_coin_s;
  logic [VAL_W-1:0]     pay_remaining_s;
  logic                 pay_active_s;
  logic                 pay_done_s;

  // Table lookup for the selected slot; out-of-range slots read as disabled.
  always_comb begin
    sel_price_s = 10'd0;
    sel_stock_s = 4'd0;
    if (sel_slot <= LAST_SLOT) begin
      sel_price_s = {1'b0, price_q[sel_slot]};
      sel_stock_s = stock_q[sel_slot];
    end else begin
      sel_price_s = 10'd0;
      sel_stock_s = 4'd0;
    end
    sel_ok_s   = (sel_price_s != 10'd0) && (sel_stock_s != 4'd0) &&
                 (credit_q >= sel_price_s);
    coin_val_s = coin_value(coin_code);
    // One extra bit so the limit check cannot wrap.
    sum_s      = {1'b0, credit_q} + {1'b0, coin_val_s};
  end

  vend_payout u_payout (
    .clk          (clk),
    .reset        (reset),
    .start_i      (pay_start_q),
    .amount_i     (change_q),
    .eject_ack_i  (eject_ack),
    .eject_req_o  (pay_req_s),
    .eject_coin_o (pay_coin_s),
    .remaining_o  (pay_remaining_s),
    .active_o     (pay_active_s),
    .done_o       (pay_done_s)
  );

  // Transaction FSM with table, LED and display registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      credit_q     <= 10'd0;
      change_q     <= 10'd0;
      disp_req_q   <= 1'b0;
      disp_slot_q  <= 4'd0;
      ret_req_q    <= 1'b0;
      ret_coin_q   <= 3'd0;
      disp_value_q <= 10'd0;
      disp_mode_q  <= MODE_CREDIT;
      busy_q       <= 1'b0;
      pay_start_q  <= 1'b0;
      grn_q        <= {NUM_SLOTS{1'b0}};
      red_q        <= {NUM_SLOTS{1'b1}};
      for (int i = 0; i < NUM_SLOTS; i++) begin
        price_q[i] <= 9'd0;
        stock_q[i] <= 4'd0;
      end
    end else begin
      pay_start_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        grn_q[i] <= (credit_q >= {1'b0, price_q[i]}) && (price_q[i] != 9'd0) &&
                    (stock_q[i] != 4'd0) && (credit_q != 10'd0);
        red_q[i] <= (price_q[i] == 9'd0) || (stock_q[i] == 4'd0);
      end

      case (state_q)
        IDLE: begin
          if (cancel) begin
            // nothing to refund
          end else if (sel_valid) begin
            disp_value_q <= sel_price_s;
            disp_mode_q  <= MODE_PRICE;
          end else if (coin_valid) begin
            // Any coin fits when credit is zero, so no limit check here.
            if (coin_is_valid(coin_code)) begin
              credit_q     <= coin_val_s;
              disp_value_q <= coin_val_s;
              disp_mode_q  <= MODE_CREDIT;
              state_q      <= CREDIT;
            end
          end else if (cfg_we && (cfg_slot <= LAST_SLOT)) begin
            price_q[cfg_slot] <= cfg_price;
            stock_q[cfg_slot] <= cfg_stock;
          end
        end

        CREDIT: begin
          if (cancel) begin
            change_q     <= credit_q;
            credit_q     <= 10'd0;
            disp_value_q <= credit_q;
            disp_mode_q  <= MODE_CHANGE;
            if (credit_q != 10'd0) begin
              pay_start_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= PAYOUT;
            end else begin
              state_q <= IDLE;
            end
          end else if (sel_valid) begin
            if (sel_ok_s) begin
              change_q             <= credit_q - sel_price_s;
              credit_q             <= 10'd0;
              stock_q[sel_slot]    <= sel_stock_s - 4'd1;
              disp_req_q           <= 1'b1;
              disp_slot_q          <= sel_slot;
              disp_value_q         <= credit_q - sel_price_s;
              disp_mode_q          <= MODE_CHANGE;
              busy_q               <= 1'b1;
              state_q              <= DISPENSE;
            end else begin
              disp_value_q <= sel_price_s;
              disp_mode_q  <= MODE_PRICE;
            end
          end else if (coin_valid && coin_is_valid(coin_code)) begin
            if (sum_s <= (VAL_W+1)'(MAX_CREDIT)) begin
              credit_q     <= sum_s[VAL_W-1:0];
              disp_value_q <= sum_s[VAL_W-1:0];
              disp_mode_q  <= MODE_CREDIT;
            end else begin
              ret_req_q  <= 1'b1;
              ret_coin_q <= coin_code;
              busy_q     <= 1'b1;
              state_q    <= RETURN;
            end
          end
        end

        DISPENSE: begin
          if (dispense_ack && disp_req_q) begin
            disp_req_q <= 1'b0;
            if (change_q != 10'd0) begin
              pay_start_q <= 1'b1;
              state_q     <= PAYOUT;
            end else begin
              disp_value_q <= 10'd0;
              disp_mode_q  <= MODE_CREDIT;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end
          end
        end

        PAYOUT: begin
          if (pay_done_s) begin
            change_q     <= 10'd0;
            disp_value_q <= 10'd0;
            disp_mode_q  <= MODE_CREDIT;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else if (pay_active_s) begin
            // Track the payer so the display counts the change down.
            change_q     <= pay_remaining_s;
            disp_value_q <= pay_remaining_s;
          end
        end

        RETURN: begin
          if (eject_ack && ret_req_q) begin
            ret_req_q    <= 1'b0;
            disp_value_q <= credit_q;
            disp_mode_q  <= MODE_CREDIT;
            busy_q       <= 1'b0;
            state_q      <= CREDIT;
          end
        end

        default: begin
          disp_req_q <= 1'b0;
          ret_req_q  <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // The payer and the rejected-coin return never run at the same time.
  assign eject_req     = pay_req_s | ret_req_q;
  assign eject_coin    = ret_req_q ? ret_coin_q : pay_coin_s;
  assign dispense_req  = disp_req_q;
  assign dispense_slot = disp_slot_q;
  assign credit        = credit_q;
  assign disp_value    = disp_value_q;
  assign disp_mode     = disp_mode_q;
  assign grn_led       = grn_q;
  assign red_led       = red_q;
  assign busy          = busy_q;

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Synchronous transaction sequencer for the vending machine.
- Accepts one-cycle coin, selection and cancel strobes, and keeps a per-slot price and stock table.
- Drives the dispenser and the coin ejector through req/ack handshakes, and owns credit, change and LED state.
- Sits between the debounced button/coin front end and the 7-segment display formatter.

Parameters:
- NUM_SLOTS, 9, slots A1..C3 mapped to indices 0..8.
- MAX_CREDIT, 500, maximum accepted credit in cents.
- VAL_W, 10, width of credit and change arithmetic in cents.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- coin_valid  in  1  one-cycle strobe: a coin has been inserted.
- coin_code  in  3  coin type: 0=5c, 1=10c, 2=25c, 3=50c, 4=100c, 5=500c; 6 and 7 are invalid.
- sel_valid  in  1  one-cycle strobe: an item has been selected.
- sel_slot  in  4  selected slot, 0..8.
- cancel  in  1  one-cycle strobe: cancel and refund.
- cfg_we  in  1  price/stock table write enable.
- cfg_slot  in  4  slot being written.
- cfg_price  in  9  price in cents; 0 marks the slot disabled.
- cfg_stock  in  4  item count for the slot.
- dispense_req  out  1  dispense request, held until acknowledged.
- dispense_slot  out  4  slot being dispensed.
- dispense_ack  in  1  dispenser has completed the item.
- eject_req  out  1  coin eject request, held until acknowledged.
- eject_coin  out  3  coin_code of the coin to eject.
- eject_ack  in  1  ejector has released one coin.
- credit  out  VAL_W  current inserted credit.
- disp_value  out  VAL_W  value to show on the display.
- disp_mode  out  2  0=credit, 1=price, 2=change.
- grn_led  out  NUM_SLOTS  slot is affordable and in stock.
- red_led  out  NUM_SLOTS  slot is out of stock or disabled.
- busy  out  1  high in DISPENSE, PAYOUT or RETURN.

Behaviour:
- Clock and reset:
  - Single clock; reset is synchronous and active-high.
  - Reset clears state to IDLE and zeroes credit, change, all prices and all stock.
  - Reset drives dispense_req=0, eject_req=0, disp_value=0, disp_mode=0 and busy=0.
  - After reset all red_led are 1 and all grn_led are 0.
  - Reset mid-handshake drops the request in the same edge; any pending refund is lost by design.
- LED rules (registered, updated every cycle):
  - grn_led[i] = (credit >= price[i]) && price[i] != 0 && stock[i] != 0 && credit != 0.
  - red_led[i] = (price[i] == 0) || (stock[i] == 0).
- Strobe priority within one cycle: cancel > sel_valid > coin_valid > cfg_we. Lower-priority strobes in that cycle are dropped.
- IDLE (credit==0):
  - Coin: credit <= coin value; go to CREDIT.
  - Selection: disp_value <= price[sel_slot], disp_mode <= 1; stay in IDLE.
  - cfg_we: write the table entry (accepted only in IDLE); cfg_slot > 8 is ignored.
  - Cancel: no-op.
- CREDIT:
  - Coin with credit + value <= MAX_CREDIT: add it; disp_mode <= 0.
  - Coin with credit + value > MAX_CREDIT: credit is unchanged; go to RETURN with eject_coin = coin_code.
  - Selection of a valid slot (price != 0, stock != 0, credit >= price):
    - change <= credit - price; credit <= 0; stock decremented.
    - dispense_req <= 1 on the next cycle; go to DISPENSE.
  - Any other selection, including sel_slot > 8: show the price (disp_mode=1) and stay in CREDIT.
  - Cancel: change <= credit; credit <= 0; go to PAYOUT, or to IDLE if change==0.
- Invalid codes: coin_code 6 or 7 is ignored in every state.
- DISPENSE:
  - Hold dispense_req and dispense_slot until dispense_ack is sampled high.
  - On ack, drop the request the next cycle; go to PAYOUT if change != 0, else to IDLE.
  - Show change (disp_mode=2).
- PAYOUT (greedy change return):
  - Each cycle, pick the largest coin of 100/25/10/5 that is <= change.
  - Assert eject_req with eject_coin set and hold both stable until eject_ack.
  - On ack: change -= coin value; deassert eject_req for at least one cycle before the next coin.
  - When change < 5, force change to 0 and go to IDLE; disp_value is then 0.
- RETURN: assert eject_req for the rejected coin until eject_ack, then go back to CREDIT.
- Strobes during busy states: coin, selection, cancel and cfg strobes in DISPENSE, PAYOUT or RETURN are dropped, with no queuing.
- Acknowledges without a request: dispense_ack or eject_ack while the matching request is low is ignored.
- Arithmetic is unsigned VAL_W-bit throughout; credit never exceeds MAX_CREDIT.

Decomposition:
- Package vend_pkg contains:
  - Coin code constants and the coin value function.
  - State enum: IDLE, CREDIT, DISPENSE, PAYOUT, RETURN.
  - NUM_SLOTS, MAX_CREDIT, and the disp_mode constants.
- One natural sub-module, vend_payout: the greedy coin picker plus the eject handshake FSM. It takes start and amount, and returns done.

Test Plan:
- Config A1 = 100c with stock 2; insert 25, 25, 50 -> credit=100 and grn_led[0]=1.
  Select A1 -> dispense_req with dispense_slot=0; ack -> stock=1, credit=0, change=0, back to IDLE.
- Config B3 = 250c; insert 500; select B3 -> dispense, then ejects of 100, 100, 25, 25 each acked; change=0 at the end.
- Insert 500, then 25 -> RETURN ejects coin_code 2; credit stays 500.
- Insert 10, 25, then cancel -> PAYOUT ejects 25 then 10; IDLE with credit=0.
- Slot with stock 0 and credit 300: select it -> no dispense_req; disp_mode=1; red_led set.
- Cancel and selection in the same cycle with credit 100 -> refund of 100, no dispense.
  Reset asserted mid-PAYOUT -> eject_req=0 on the next edge, all state cleared.
